// File: rtl/tof_sample_collector_if.sv
// rtl/tof_sample_collector_if.sv - sample stream from the collector to the host-side packetiser
interface tof_sample_collector_if;
  logic        out_valid;
  logic        out_ready;
  logic [2:0]  out_sensor;
  logic [5:0]  out_zone;
  logic [15:0] out_distance;

  modport master (output out_valid, out_sensor, out_zone, out_distance, input out_ready);
  modport slave  (input out_valid, out_sensor, out_zone, out_distance, output out_ready);
endinterface

// File: rtl/tof_sample_collector.sv
// rtl/tof_sample_collector.sv - round-robin ToF sample scanner with tagged sample FIFO
module tof_sample_collector #(
  parameter int          FIFO_DEPTH  = 8,
  parameter logic [7:0]  SENSOR_MASK = 8'hFF
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          enable,
  input  logic [7:0]                    ready_in,
  input  logic [21:0]                   data_in,
  output logic [2:0]                    tof_index,
  tof_sample_collector_if.master        out_if,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          frame_done,
  output logic                          overflow,
  output logic [7:0]                    drop_count
);

  localparam int AW    = $clog2(FIFO_DEPTH);
  localparam int LVL_W = AW + 1;

  typedef enum logic {IDLE, SCAN} state_t;

  state_t          state, state_nxt;
  logic            capture, push, pop, full, frame_hit;
  logic [7:0]      cap_bit, seen;
  logic [AW-1:0]   wr_ptr, rd_ptr;
  logic [24:0]     mem [FIFO_DEPTH];

  // Smallest forward distance to a masked sensor wins; a lone or empty mask holds the index.
  function automatic logic [2:0] next_masked(input logic [2:0] s);
    logic [2:0] n;
    next_masked = s;
    for (int k = 7; k >= 1; k--) begin
      n = s + 3'(k);
      if (SENSOR_MASK[n]) next_masked = n;
    end
  endfunction

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (enable)  state_nxt = SCAN;
      SCAN:    if (!enable) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    capture    = 1'b0;
    cap_bit    = 8'h00;
    frame_hit  = 1'b0;
    if (state == SCAN) begin
      capture = SENSOR_MASK[tof_index] & ready_in[tof_index];
    end
    if (capture) cap_bit = 8'b1 << tof_index;
    frame_hit  = capture && (((seen | cap_bit) & SENSOR_MASK) == SENSOR_MASK);
    frame_done = frame_hit;
  end

  assign full              = (fifo_level == LVL_W'(FIFO_DEPTH));
  assign out_if.out_valid  = (fifo_level != '0);
  assign pop               = out_if.out_valid & out_if.out_ready;
  // A full FIFO still accepts when the head leaves in the same cycle.
  assign push              = capture & (~full | pop);
  assign {out_if.out_sensor, out_if.out_zone, out_if.out_distance} = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {tof_index, data_in};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tof_index  <= 3'd0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_level <= '0;
      seen       <= 8'h00;
      overflow   <= 1'b0;
      drop_count <= 8'h00;
    end else begin
      if (state == SCAN) tof_index <= next_masked(tof_index);
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   fifo_level <= fifo_level + LVL_W'(1);
        2'b01:   fifo_level <= fifo_level - LVL_W'(1);
        default: fifo_level <= fifo_level;
      endcase
      if (capture) seen <= frame_hit ? 8'h00 : (seen | cap_bit);
      if (capture && !push) begin
        overflow <= 1'b1;
        if (drop_count != 8'hFF) drop_count <= drop_count + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_tof_sample_collector.sv
// tb/tb_tof_sample_collector.sv - directed-vector bench for tof_sample_collector
module tb_tof_sample_collector;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        enable = 1'b0, enable_b = 1'b0;
  logic [7:0]  ready_in = 8'h00, ready_b = 8'h00;
  logic [21:0] data_in, data_b;
  logic [2:0]  tof_index, idx_b;
  logic [3:0]  fifo_level, level_b;
  logic        frame_done, frame_done_b, overflow, overflow_b;
  logic [7:0]  drop_count, drop_b;
  int          vectors = 0;
  int          miscompares = 0;

  tof_sample_collector_if sif();
  tof_sample_collector_if sif_b();

  always #5 clk = ~clk;

  // Upstream model: sensor i reports zone i+2, distance 0x0120+i.
  assign data_in = {6'(tof_index) + 6'd2, 16'h0120 + 16'(tof_index)};
  assign data_b  = {6'(idx_b) + 6'd2, 16'h0120 + 16'(idx_b)};

  tof_sample_collector #(.FIFO_DEPTH(8), .SENSOR_MASK(8'hFF)) dut (
    .clk(clk), .reset(reset), .enable(enable), .ready_in(ready_in), .data_in(data_in),
    .tof_index(tof_index), .out_if(sif.master), .fifo_level(fifo_level),
    .frame_done(frame_done), .overflow(overflow), .drop_count(drop_count));

  tof_sample_collector #(.FIFO_DEPTH(8), .SENSOR_MASK(8'b0000_0101)) dut_b (
    .clk(clk), .reset(reset), .enable(enable_b), .ready_in(ready_b), .data_in(data_b),
    .tof_index(idx_b), .out_if(sif_b.master), .fifo_level(level_b),
    .frame_done(frame_done_b), .overflow(overflow_b), .drop_count(drop_b));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_index(input logic [2:0] target);
    int n = 0;
    while (tof_index !== target && n < 20) begin tick(); n++; end
    vectors++;
    if (tof_index !== target) begin miscompares++; $display("FAIL wait_index got=%0d want=%0d", tof_index, target); end
  endtask

  task automatic test_reset();
    sif.out_ready = 1'b0; sif_b.out_ready = 1'b1;
    tick(); tick();
    vectors += 6;
    if (tof_index !== 3'd0)   begin miscompares++; $display("FAIL reset_index got=%0d want=0", tof_index); end
    if (sif.out_valid !== 1'b0) begin miscompares++; $display("FAIL reset_valid got=%0b want=0", sif.out_valid); end
    if (fifo_level !== 4'd0)  begin miscompares++; $display("FAIL reset_level got=%0d want=0", fifo_level); end
    if (frame_done !== 1'b0)  begin miscompares++; $display("FAIL reset_frame got=%0b want=0", frame_done); end
    if (overflow !== 1'b0)    begin miscompares++; $display("FAIL reset_overflow got=%0b want=0", overflow); end
    if (drop_count !== 8'd0)  begin miscompares++; $display("FAIL reset_drops got=%0d want=0", drop_count); end
    reset = 1'b0;
  endtask

  task automatic test_mask_b();
    logic [2:0] exp;
    enable_b = 1'b1; ready_b = 8'h02;
    tick();
    vectors++;
    if (idx_b !== 3'd0) begin miscompares++; $display("FAIL maskb_start got=%0d want=0", idx_b); end
    for (int i = 0; i < 6; i++) begin
      tick();
      exp = (i % 2 == 0) ? 3'd2 : 3'd0;
      vectors += 2;
      if (idx_b !== exp) begin miscompares++; $display("FAIL maskb_index got=%0d want=%0d", idx_b, exp); end
      if (sif_b.out_valid !== 1'b0) begin miscompares++; $display("FAIL maskb_ignore got=%0b want=0", sif_b.out_valid); end
    end
    ready_b = 8'h07;
    vectors++;
    if (frame_done_b !== 1'b0) begin miscompares++; $display("FAIL maskb_frame0 got=%0b want=0", frame_done_b); end
    tick();
    vectors += 3;
    if (frame_done_b !== 1'b1) begin miscompares++; $display("FAIL maskb_frame2 got=%0b want=1", frame_done_b); end
    if (sif_b.out_valid !== 1'b1) begin miscompares++; $display("FAIL maskb_valid got=%0b want=1", sif_b.out_valid); end
    if (sif_b.out_sensor !== 3'd0) begin miscompares++; $display("FAIL maskb_head0 got=%0d want=0", sif_b.out_sensor); end
    tick();
    vectors += 4;
    if (sif_b.out_sensor !== 3'd2) begin miscompares++; $display("FAIL maskb_head2 got=%0d want=2", sif_b.out_sensor); end
    if (sif_b.out_zone !== 6'd4)   begin miscompares++; $display("FAIL maskb_zone got=%0d want=4", sif_b.out_zone); end
    if (level_b !== 4'd1)          begin miscompares++; $display("FAIL maskb_level got=%0d want=1", level_b); end
    if (frame_done_b !== 1'b0)     begin miscompares++; $display("FAIL maskb_frame_again got=%0b want=0", frame_done_b); end
    ready_b = 8'h00;
  endtask

  task automatic test_idle_scan();
    enable = 1'b1; ready_in = 8'h00;
    tick();
    vectors++;
    if (tof_index !== 3'd0) begin miscompares++; $display("FAIL scan_start got=%0d want=0", tof_index); end
    for (int k = 1; k < 16; k++) begin
      tick();
      vectors += 3;
      if (tof_index !== 3'(k % 8)) begin miscompares++; $display("FAIL scan_index got=%0d want=%0d", tof_index, k % 8); end
      if (sif.out_valid !== 1'b0) begin miscompares++; $display("FAIL scan_valid got=%0b want=0", sif.out_valid); end
      if (frame_done !== 1'b0) begin miscompares++; $display("FAIL scan_frame got=%0b want=0", frame_done); end
    end
  endtask

  task automatic test_single_capture();
    wait_index(3'd2);
    ready_in = 8'h08;
    tick();
    vectors++;
    if (sif.out_valid !== 1'b0) begin miscompares++; $display("FAIL single_early got=%0b want=0", sif.out_valid); end
    tick();
    ready_in = 8'h00;
    vectors += 5;
    if (sif.out_valid !== 1'b1)        begin miscompares++; $display("FAIL single_valid got=%0b want=1", sif.out_valid); end
    if (sif.out_sensor !== 3'd3)       begin miscompares++; $display("FAIL single_sensor got=%0d want=3", sif.out_sensor); end
    if (sif.out_zone !== 6'd5)         begin miscompares++; $display("FAIL single_zone got=%0d want=5", sif.out_zone); end
    if (sif.out_distance !== 16'h0123) begin miscompares++; $display("FAIL single_dist got=%h want=0123", sif.out_distance); end
    if (fifo_level !== 4'd1)           begin miscompares++; $display("FAIL single_level got=%0d want=1", fifo_level); end
    sif.out_ready = 1'b1;
    tick();
    sif.out_ready = 1'b0;
    vectors++;
    if (fifo_level !== 4'd0) begin miscompares++; $display("FAIL single_pop got=%0d want=0", fifo_level); end
  endtask

  task automatic test_all_ready();
    wait_index(3'd0);
    sif.out_ready = 1'b1; ready_in = 8'hFF;
    for (int k = 0; k < 8; k++) begin
      vectors += 2;
      if (tof_index !== 3'(k)) begin miscompares++; $display("FAIL all_index got=%0d want=%0d", tof_index, k); end
      if (frame_done !== (k == 7)) begin miscompares++; $display("FAIL all_frame k=%0d got=%0b want=%0b", k, frame_done, k == 7); end
      tick();
      vectors += 3;
      if (sif.out_sensor !== 3'(k)) begin miscompares++; $display("FAIL all_sensor got=%0d want=%0d", sif.out_sensor, k); end
      if (sif.out_distance !== 16'h0120 + 16'(k)) begin miscompares++; $display("FAIL all_dist got=%h want=%h", sif.out_distance, 16'h0120 + 16'(k)); end
      if (fifo_level !== 4'd1) begin miscompares++; $display("FAIL all_level got=%0d want=1", fifo_level); end
    end
    ready_in = 8'h00;
    tick();
    sif.out_ready = 1'b0;
    vectors += 3;
    if (fifo_level !== 4'd0) begin miscompares++; $display("FAIL all_drain got=%0d want=0", fifo_level); end
    if (drop_count !== 8'd0) begin miscompares++; $display("FAIL all_drops got=%0d want=0", drop_count); end
    if (overflow !== 1'b0)   begin miscompares++; $display("FAIL all_overflow got=%0b want=0", overflow); end
  endtask

  task automatic test_overflow();
    wait_index(3'd0);
    ready_in = 8'hFF;
    for (int k = 0; k < 10; k++) tick();
    ready_in = 8'h00;
    vectors += 4;
    if (fifo_level !== 4'd8)     begin miscompares++; $display("FAIL ovf_level got=%0d want=8", fifo_level); end
    if (overflow !== 1'b1)       begin miscompares++; $display("FAIL ovf_flag got=%0b want=1", overflow); end
    if (drop_count !== 8'd2)     begin miscompares++; $display("FAIL ovf_drops got=%0d want=2", drop_count); end
    if (sif.out_sensor !== 3'd0) begin miscompares++; $display("FAIL ovf_head got=%0d want=0", sif.out_sensor); end
  endtask

  task automatic test_full_pop_push();
    logic [2:0] order [8] = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7, 3'd2};
    wait_index(3'd2);
    ready_in = 8'h04; sif.out_ready = 1'b1;
    tick();
    ready_in = 8'h00; sif.out_ready = 1'b0;
    vectors += 3;
    if (fifo_level !== 4'd8)     begin miscompares++; $display("FAIL fullpp_level got=%0d want=8", fifo_level); end
    if (drop_count !== 8'd2)     begin miscompares++; $display("FAIL fullpp_drops got=%0d want=2", drop_count); end
    if (sif.out_sensor !== 3'd1) begin miscompares++; $display("FAIL fullpp_head got=%0d want=1", sif.out_sensor); end
    sif.out_ready = 1'b1;
    for (int j = 0; j < 8; j++) begin
      vectors++;
      if (sif.out_sensor !== order[j]) begin miscompares++; $display("FAIL drain_order j=%0d got=%0d want=%0d", j, sif.out_sensor, order[j]); end
      if (j == 7) begin
        vectors++;
        if (sif.out_distance !== 16'h0122) begin miscompares++; $display("FAIL drain_last got=%h want=0122", sif.out_distance); end
      end
      tick();
    end
    sif.out_ready = 1'b0;
    vectors += 2;
    if (fifo_level !== 4'd0)    begin miscompares++; $display("FAIL drain_level got=%0d want=0", fifo_level); end
    if (sif.out_valid !== 1'b0) begin miscompares++; $display("FAIL drain_valid got=%0b want=0", sif.out_valid); end
  endtask

  task automatic test_enable_off();
    wait_index(3'd5);
    ready_in = 8'h20; enable = 1'b0;
    tick();
    ready_in = 8'h00;
    vectors += 3;
    if (fifo_level !== 4'd1)     begin miscompares++; $display("FAIL en_capture got=%0d want=1", fifo_level); end
    if (tof_index !== 3'd6)      begin miscompares++; $display("FAIL en_advance got=%0d want=6", tof_index); end
    if (sif.out_sensor !== 3'd5) begin miscompares++; $display("FAIL en_sensor got=%0d want=5", sif.out_sensor); end
    ready_in = 8'hFF;
    tick(); tick();
    ready_in = 8'h00;
    vectors += 2;
    if (tof_index !== 3'd6)  begin miscompares++; $display("FAIL en_hold got=%0d want=6", tof_index); end
    if (fifo_level !== 4'd1) begin miscompares++; $display("FAIL en_nocap got=%0d want=1", fifo_level); end
    sif.out_ready = 1'b1;
    tick();
    sif.out_ready = 1'b0;
    enable = 1'b1;
    tick();
    tick();
    vectors += 2;
    if (fifo_level !== 4'd0) begin miscompares++; $display("FAIL en_drain got=%0d want=0", fifo_level); end
    if (tof_index !== 3'd7)  begin miscompares++; $display("FAIL en_resume got=%0d want=7", tof_index); end
  endtask

  task automatic test_saturation();
    ready_in = 8'hFF; sif.out_ready = 1'b0;
    for (int k = 0; k < 300; k++) tick();
    ready_in = 8'h00;
    vectors += 3;
    if (drop_count !== 8'd255) begin miscompares++; $display("FAIL sat_drops got=%0d want=255", drop_count); end
    if (fifo_level !== 4'd8)   begin miscompares++; $display("FAIL sat_level got=%0d want=8", fifo_level); end
    if (overflow !== 1'b1)     begin miscompares++; $display("FAIL sat_overflow got=%0b want=1", overflow); end
  endtask

  task automatic test_reset_mid();
    sif.out_ready = 1'b1;
    tick(); tick(); tick();
    sif.out_ready = 1'b0;
    vectors++;
    if (fifo_level !== 4'd5) begin miscompares++; $display("FAIL mid_pre_level got=%0d want=5", fifo_level); end
    #2 reset = 1'b1;
    #1;
    vectors += 5;
    if (fifo_level !== 4'd0)    begin miscompares++; $display("FAIL mid_level got=%0d want=0", fifo_level); end
    if (sif.out_valid !== 1'b0) begin miscompares++; $display("FAIL mid_valid got=%0b want=0", sif.out_valid); end
    if (tof_index !== 3'd0)     begin miscompares++; $display("FAIL mid_index got=%0d want=0", tof_index); end
    if (overflow !== 1'b0)      begin miscompares++; $display("FAIL mid_overflow got=%0b want=0", overflow); end
    if (drop_count !== 8'd0)    begin miscompares++; $display("FAIL mid_drops got=%0d want=0", drop_count); end
    tick();
    reset = 1'b0;
  endtask

  initial begin
    test_reset();
    test_mask_b();
    test_idle_scan();
    test_single_capture();
    test_all_ready();
    test_overflow();
    test_full_pop_push();
    test_enable_off();
    test_saturation();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
